// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH in WIDTH+1 cycles behind start/done.
// Define SEQ_MULTIPLIER_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_nxt, result;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic sign;
  // Magnitude stays WIDTH bits unsigned, so the most-negative input maps to 2^(WIDTH-1) exactly.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = sign ? -acc_nxt : acc_nxt;
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_nxt;
`endif

  // One iteration: conditional add into the upper half with carry kept, then shift right.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) sum = sum + {1'b0, mcand};
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      sign   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // p is loaded from the final iteration's value on the edge into DONE.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            p     <= result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances, vector table plus corner sequences.
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic signed [7:0] sx, sy;
    sx = 8'(signed'(x));
    sy = 8'(signed'(y));
    return 8'(sx * sy);
`else
    return 8'({4'b0, x} * {4'b0, y});
`endif
  endfunction

  // One WIDTH=4 operation: start for one cycle, measure latency and busy cycles, check p and hold.
  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] ep,
                     input string nm, input bit full);
    int lat, nbusy;
    bit both;
    @(negedge clk); a4 = ia; b4 = ib; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    lat = 1; nbusy = 0; both = 0;
    while (!done4 && lat < 20) begin
      if (busy4) nbusy++;
      @(negedge clk); lat++;
    end
    if (busy4 && done4) both = 1;
    chk({nm, " p"}, 32'(p4), 32'(ep));
    if (full) begin
      chk({nm, " latency"}, lat, 5);
      chk({nm, " busy cycles"}, nbusy, 4);
      chk({nm, " busy&done"}, 32'(both), 0);
      @(negedge clk);
      chk({nm, " done one cycle"}, 32'(done4), 0);
      chk({nm, " p hold"}, 32'(p4), 32'(ep));
    end
  endtask

  initial begin
    vec_t vt[6];
    int n, d1, d2;
    bit both, seen;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    vt[0] = '{4'hD, 4'h5, 8'hF1};
    vt[1] = '{4'h8, 4'h8, 8'h40};
    vt[2] = '{4'h8, 4'h7, 8'hC8};
    vt[3] = '{4'hF, 4'hF, 8'h01};
    vt[4] = '{4'h0, 4'h9, 8'h00};
    vt[5] = '{4'h7, 4'h3, 8'h15};
`else
    vt[0] = '{4'hD, 4'h5, 8'h41};
    vt[1] = '{4'hF, 4'hF, 8'hE1};
    vt[2] = '{4'h0, 4'h9, 8'h00};
    vt[3] = '{4'h1, 4'h1, 8'h01};
    vt[4] = '{4'h7, 4'h3, 8'h15};
    vt[5] = '{4'h8, 4'h2, 8'h10};
`endif
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy4", 32'(busy4), 0);
    chk("reset done4", 32'(done4), 0);
    chk("reset p4", 32'(p4), 0);
    chk("reset busy8", 32'(busy8), 0);
    chk("reset p8", 32'(p8), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      op4(vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i), 1'b1);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y), model4(4'(x), 4'(y)), $sformatf("sweep %0d*%0d", x, y), 1'b0);

    // Back-to-back at WIDTH=8 with start held; operand change while busy must not be picked up.
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk); a8 = 8'd3; b8 = 8'd7;
    n = 1; d1 = 0; d2 = 0; both = 0;
    while (n < 40 && d2 == 0) begin
      if (busy8 && done8) both = 1;
      if (done8) begin
        if (d1 == 0) begin
          d1 = n;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
          chk("b2b first p", 32'(p8), 32'h0001);
`else
          chk("b2b first p", 32'(p8), 32'hFE01);
`endif
        end else begin
          d2 = n;
          chk("b2b second p", 32'(p8), 32'h0015);
          start8 = 1'b0;
        end
      end
      @(negedge clk); n++;
    end
    chk("b2b first latency", d1, 9);
    chk("b2b spacing", d2 - d1, 9);
    chk("b2b busy&done", 32'(both), 0);
    start8 = 1'b0;

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk); a4 = 4'h9; b4 = 4'h9; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst busy", 32'(busy4), 0);
    chk("midrst done", 32'(done4), 0);
    chk("midrst p", 32'(p4), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 || busy4) seen = 1;
    end
    chk("midrst no done", 32'(seen), 0);
    op4(4'h6, 4'h3, model4(4'h6, 4'h3), "after rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, computed one partial-product bit per clock. It is the successor to the team's fixed 4-bit combinational array multiplier. It trades the array multiplier's area for WIDTH+1 cycles of latency behind a start/done handshake, so wide multiplies (8/16/32-bit) fit the lab datapaths. An optional signed mode is compiled in by macro.

## Interface

- WIDTH, default 4: operand width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on each rising edge; accepted only when busy=0.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; p is valid in that cycle.
- p  output  2*WIDTH  product; holds its value until the next accepted start.

## Operation

- States:
  - IDLE: reset state.
  - RUN: iterate.
  - DONE: result presented.
- IDLE: start=1 -> latch a into multiplicand register and b into multiplier shift register; clear accumulator and iteration counter; go to RUN. start=0 -> stay.
- RUN, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper WIDTH+1 bits of the accumulator.
  - Shift {carry, accumulator} right by 1.
  - Shift the multiplier register right by 1.
  - Increment the counter.
  - After exactly WIDTH iterations, go to DONE.
- DONE: register the accumulator into p, assert done for this cycle only, then go to IDLE.
  - start=1 in DONE is accepted: back-to-back operation, go directly to RUN with new operands.
- start while busy=1 is ignored. No queuing, and operands are not re-sampled.
- Arithmetic: the unsigned result is exact; the product of two WIDTH-bit values always fits in 2*WIDTH bits. The carry out of the add is kept (WIDTH+1-bit adder), so no overflow is possible.
- Counter width is clog2(WIDTH)+1. No early termination on a zero multiplier: latency is data-independent.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, p=0, internal registers cleared. The in-flight operation is discarded and no done is produced.

## Timing

- Accepting edge = cycle 0.
- busy=1 during cycles 1..WIDTH. done=1 and p valid in cycle WIDTH+1.
- Latency from start to done: WIDTH+1 cycles.
- Throughput: one result per WIDTH+1 cycles with start held high continuously.
- done and busy are never high together.
- p changes only on the edge that enters DONE.
- Reset output values: busy=0, done=0, p=0.

## Configuration

- Macro: SEQ_MULTIPLIER_SIGNED_EN.
- Defined: a and b are two's-complement signed.
  - On the accepting edge, the magnitudes |a| and |b| are latched, along with sign = a[MSB] ^ b[MSB].
  - The RUN phase is identical.
  - On entry to DONE, p = sign ? -acc : acc, as 2*WIDTH-bit two's complement.
  - Most-negative inputs are handled: the magnitude register is WIDTH bits unsigned, so |-2^(WIDTH-1)| is representable.
  - Latency is unchanged.
- Undefined: purely unsigned operation; no sign logic is synthesised.

## Test plan

- WIDTH=4, unsigned: a=4'hD, b=4'h5, start for 1 cycle -> busy for 4 cycles; done in cycle 5 with p=8'h41; p holds 8'h41 afterward.
- WIDTH=4, unsigned extremes: 15*15 -> p=8'hE1; 0*9 -> p=8'h00 after the full 5-cycle latency. Then exhaustive sweep of all 256 pairs against a behavioural a*b.
- WIDTH=8, back-to-back: start held high with 255*255 then 3*7 -> done pulses exactly 9 cycles apart; p=16'hFE01, then 16'h0015. start while busy leaves the result unaffected.
- Reset mid-operation: assert rst in cycle 2 of RUN -> next cycle busy=0, done=0, p=0; no done pulse follows. A new start afterwards completes normally.
- SEQ_MULTIPLIER_SIGNED_EN, WIDTH=4:
  - a=4'hD (-3), b=4'h5 -> p=8'hF1 (-15).
  - a=4'h8, b=4'h8 (-8*-8) -> p=8'h40.
  - a=4'h8, b=4'h7 -> p=8'hC8 (-56).
  - Latency is still 5 cycles in all cases.
